// File: rtl/iob_eth_tx_frame_pkg.sv
// Shared constants, FSM encoding and CRC helper for the ETH TX framer.
// ETH_TX_FCS_EN adds the FCS state encoding.
package iob_eth_tx_frame_pkg;

    localparam int          ETH_PREAMBLE_NIBBLES = 15;
    localparam logic [3:0]  ETH_PREAMBLE         = 4'h5;
    localparam logic [3:0]  ETH_SFD              = 4'hD;
    localparam int          ETH_IFG_CYCLES       = 24;
    localparam logic [31:0] ETH_CRC_POLY         = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT         = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
`ifdef ETH_TX_FCS_EN
        ST_FCS  = 3'd4,
`endif
        ST_IFG  = 3'd5
    } tx_state_e;

    // Reflected CRC-32 advanced by one nibble, low bit first.
    function automatic logic [31:0] crc_nibble(
        input logic [31:0] crc,
        input logic [3:0]  d
    );
        logic [31:0] c;
        c = crc ^ {28'd0, d};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/iob_eth_crc32_nibble.sv
// Nibble-serial IEEE 802.3 CRC-32 accumulator (raw, not inverted).
// Used by iob_eth_tx_frame only when ETH_TX_FCS_EN is defined.
module iob_eth_crc32_nibble
    import iob_eth_tx_frame_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cke_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [3:0]  data_i,
    output logic [31:0] crc_o
);

    // CRC register: seeded by init_i, advanced one nibble per enabled cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_o <= ETH_CRC_INIT;
        end else if (cke_i) begin
            if (init_i) begin
                crc_o <= ETH_CRC_INIT;
            end else if (en_i) begin
                crc_o <= crc_nibble(crc_o, data_i);
            end
        end
    end

endmodule

// File: rtl/iob_eth_tx_frame.sv
// MII TX frame serializer: preamble, SFD, buffered payload, IFG.
// Define ETH_TX_FCS_EN to append a hardware CRC-32 FCS.
module iob_eth_tx_frame
    import iob_eth_tx_frame_pkg::*;
#(
    parameter int BUF_ADDR_W = 9,
    parameter int LEN_W      = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cke_i,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      frame_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  buf_ren_o,
    output logic [BUF_ADDR_W-1:0] buf_addr_o,
    input  logic [31:0]           buf_rdata_i,
    output logic                  mii_tx_en_o,
    output logic [3:0]            mii_txd_o
);

    tx_state_e        state;
    logic [4:0]       cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   nib_cnt;
    logic [31:0]      word_q;

    logic [2:0]       nib_sel;
    logic [3:0]       cur_nib;
    logic [LEN_W-1:0] nxt_word;
    logic [LEN_W+1:0] nxt_byte;
    logic             pf_ok;
    logic             last_nib;

    // Payload nibble selection and next-word prefetch decision.
    always_comb begin
        nib_sel  = nib_cnt[2:0];
        cur_nib  = word_q[{nib_sel, 2'b00} +: 4];
        nxt_word = LEN_W'(nib_cnt[LEN_W:3]) + LEN_W'(1);
        nxt_byte = {nxt_word, 2'b00};
        pf_ok    = nxt_byte < (LEN_W+2)'(len_q);
        last_nib = nib_cnt == ({len_q, 1'b0} - (LEN_W+1)'(1));
    end

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc;
    logic [31:0] fcs_w;
    logic [3:0]  fcs_nib;

    assign fcs_w   = ~crc;
    assign fcs_nib = fcs_w[{cnt[2:0], 2'b00} +: 4];

    iob_eth_crc32_nibble u_crc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cke_i  (cke_i),
        .init_i (state == ST_IDLE),
        .en_i   (state == ST_DATA),
        .data_i (cur_nib),
        .crc_o  (crc)
    );
`endif

    // Frame FSM with registered MII, buffer and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            len_q       <= '0;
            nib_cnt     <= '0;
            word_q      <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            buf_ren_o   <= 1'b0;
            buf_addr_o  <= '0;
            mii_tx_en_o <= 1'b0;
            mii_txd_o   <= 4'h0;
        end else if (cke_i) begin
            done_o      <= 1'b0;
            buf_ren_o   <= 1'b0;
            mii_tx_en_o <= 1'b0;
            mii_txd_o   <= 4'h0;
            unique case (state)
                ST_IDLE: begin
                    if (start_i && frame_len_i != '0) begin
                        len_q   <= frame_len_i;
                        busy_o  <= 1'b1;
                        cnt     <= '0;
                        nib_cnt <= '0;
                        state   <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    mii_tx_en_o <= 1'b1;
                    mii_txd_o   <= ETH_PREAMBLE;
                    cnt         <= cnt + 5'd1;
                    if (cnt == 5'd0) begin
                        buf_ren_o  <= 1'b1;
                        buf_addr_o <= '0;
                    end
                    if (cnt == 5'(ETH_PREAMBLE_NIBBLES - 1)) begin
                        state <= ST_SFD;
                    end
                end
                ST_SFD: begin
                    mii_tx_en_o <= 1'b1;
                    mii_txd_o   <= ETH_SFD;
                    word_q      <= buf_rdata_i;
                    state       <= ST_DATA;
                end
                ST_DATA: begin
                    mii_tx_en_o <= 1'b1;
                    mii_txd_o   <= cur_nib;
                    nib_cnt     <= nib_cnt + (LEN_W+1)'(1);
                    if (nib_sel == 3'd0 && pf_ok) begin
                        buf_ren_o  <= 1'b1;
                        buf_addr_o <= nxt_word[BUF_ADDR_W-1:0];
                    end
                    if (nib_sel == 3'd7) begin
                        word_q <= buf_rdata_i;
                    end
                    if (last_nib) begin
                        cnt <= '0;
`ifdef ETH_TX_FCS_EN
                        state <= ST_FCS;
`else
                        state <= ST_IFG;
`endif
                    end
                end
`ifdef ETH_TX_FCS_EN
                ST_FCS: begin
                    mii_tx_en_o <= 1'b1;
                    mii_txd_o   <= fcs_nib;
                    cnt         <= cnt + 5'd1;
                    if (cnt == 5'd7) begin
                        cnt   <= '0;
                        state <= ST_IFG;
                    end
                end
`endif
                ST_IFG: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(ETH_IFG_CYCLES - 1)) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        cnt    <= '0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
